// File: rtl/clkdiv_pkg.sv
// Shared constants and types for the 32-bit free-running clock-divider counter.
package clkdiv_pkg;

  localparam int CNT_W    = 32;
  localparam int SLICE_W  = 4;
  localparam int N_SLICES = 8;

  typedef logic [CNT_W-1:0]   cnt_t;
  typedef logic [SLICE_W-1:0] slice_t;

  localparam cnt_t CLKDIV_RST_DEFAULT = 32'h0000_0000;

  // Terminal count of one slice: all ones, so the next slice may advance.
  function automatic logic slice_tc(input slice_t v);
    return (v == 4'hF);
  endfunction

endpackage

// File: rtl/clkdiv_slice4.sv
// One 4-bit counter slice; advances when en_in is high and flags all-ones on tc.
module clkdiv_slice4
  import clkdiv_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en_in,
  input  logic [SLICE_W-1:0] rst_val,
  output logic [SLICE_W-1:0] q,
  output logic               tc
);

  slice_t q_d;
  slice_t q_q;

  always_comb begin
    q_d = q_q;
    if (en_in) begin
      q_d = q_q + 4'd1;
    end else begin
      q_d = q_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q <= rst_val;
    end else begin
      q_q <= q_d;
    end
  end

  assign q  = q_q;
  assign tc = slice_tc(q_q);

endmodule

// File: rtl/clkdiv_32b.sv
// Free-running 32-bit timebase built from eight 4-bit slices with a lookahead carry enable.
module clkdiv_32b
  import clkdiv_pkg::*;
#(
  parameter cnt_t RST_VALUE = CLKDIV_RST_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] clkdiv
);

  logic [N_SLICES-1:0] tc_s;
  logic [N_SLICES-1:0] en_s;
  cnt_t                cnt_q;

  // Slice j advances only when every lower slice holds its terminal count;
  // the flags come straight from registers, so this is a pure AND prefix.
  always_comb begin
    en_s    = '0;
    en_s[0] = 1'b1;
    for (int j = 1; j < N_SLICES; j++) begin
      en_s[j] = en_s[j-1] & tc_s[j-1];
    end
  end

  for (genvar j = 0; j < N_SLICES; j++) begin : g_slice
    clkdiv_slice4 u_slice (
      .clk     (clk),
      .rst     (rst),
      .en_in   (en_s[j]),
      .rst_val (RST_VALUE[j*SLICE_W +: SLICE_W]),
      .q       (cnt_q[j*SLICE_W +: SLICE_W]),
      .tc      (tc_s[j])
    );
  end

  assign clkdiv = cnt_q;

endmodule

// File: tb/tb_clkdiv_32b.sv
// Directed bench for clkdiv_32b: vector table plus carry, wrap, mid-reset and long reference run.
module tb_clkdiv_32b;

  localparam logic [31:0] RV_B28  = 32'h0FFF_FFFD;
  localparam logic [31:0] RV_WRAP = 32'hFFFF_FFFE;
  localparam logic [31:0] RV_RND  = 32'hC3A5_F0F7;
  localparam int          RND_CYC = 20000;

  logic        clk;
  logic        rst0, rst_b, rst_w, rst_r;
  logic [31:0] cd0, cd_b, cd_w, cd_r;

  int total = 0;
  int bad   = 0;

  clkdiv_32b #(.RST_VALUE(32'h0000_0000)) dut0 (.clk(clk), .rst(rst0), .clkdiv(cd0));
  clkdiv_32b #(.RST_VALUE(RV_B28))  dut_b (.clk(clk), .rst(rst_b), .clkdiv(cd_b));
  clkdiv_32b #(.RST_VALUE(RV_WRAP)) dut_w (.clk(clk), .rst(rst_w), .clkdiv(cd_w));
  clkdiv_32b #(.RST_VALUE(RV_RND))  dut_r (.clk(clk), .rst(rst_r), .clkdiv(cd_r));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    int          edges;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        prev0;
    int          hi_cnt, run, max_run;
    int          mism;
    logic [31:0] model, first_act, first_exp;

    rst0 = 1'b0; rst_b = 1'b0; rst_w = 1'b0; rst_r = 1'b0;

    vecs[0] = '{rst: 1'b0, edges: 10,  exp: 32'd0,    name: "hold_rst"};
    vecs[1] = '{rst: 1'b1, edges: 1,   exp: 32'd1,    name: "release_1"};
    vecs[2] = '{rst: 1'b1, edges: 99,  exp: 32'd100,  name: "count_100"};
    vecs[3] = '{rst: 1'b1, edges: 900, exp: 32'd1000, name: "count_1000"};
    vecs[4] = '{rst: 1'b0, edges: 2,   exp: 32'd0,    name: "rst_again"};

    for (int v = 0; v < 5; v++) begin
      rst0 = vecs[v].rst;
      for (int e = 0; e < vecs[v].edges; e++) begin
        tick();
        if (!vecs[v].rst) check(vecs[v].name, cd0, vecs[v].exp);
      end
      if (vecs[v].rst) check(vecs[v].name, cd0, vecs[v].exp);
    end

    // Low slice carry boundaries
    rst0 = 1'b1;
    repeat (15) tick();
    check("at_15", cd0, 32'd15);
    tick();
    check("carry_16", cd0, 32'd16);
    repeat (239) tick();
    check("at_255", cd0, 32'd255);
    tick();
    check("carry_256", cd0, 32'd256);

    prev0 = cd0[0];
    for (int i = 0; i < 16; i++) begin
      tick();
      check("bit0_toggle", {31'd0, cd0[0]}, {31'd0, ~prev0});
      prev0 = cd0[0];
    end

    hi_cnt = 0; run = 0; max_run = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (i < 16 && cd0[3]) hi_cnt++;
      if (cd0[3]) run++;
      else run = 0;
      if (run > max_run) max_run = run;
    end
    check("bit3_high_per16", hi_cnt, 32'd8);
    check("bit3_max_run", max_run, 32'd8);

    // Reset asserted between edges must not act until the next rising edge
    rst0 = 1'b0;
    tick();
    check("mid_pre_rst", cd0, 32'd0);
    rst0 = 1'b1;
    repeat (37) tick();
    check("mid_37", cd0, 32'd37);
    #4;
    rst0 = 1'b0;
    #1;
    check("mid_hold_37", cd0, 32'd37);
    tick();
    check("mid_rst_load", cd0, 32'd0);
    #4;
    rst0 = 1'b1;
    tick();
    check("mid_release", cd0, 32'd1);

    // Upper-slice carry via preload
    check("b28_rst", cd_b, RV_B28);
    rst_b = 1'b1;
    tick();
    check("b28_fffe", cd_b, 32'h0FFF_FFFE);
    tick();
    check("b28_ffff", cd_b, 32'h0FFF_FFFF);
    tick();
    check("b28_carry", cd_b, 32'h1000_0000);

    check("wrap_rst", cd_w, RV_WRAP);
    rst_w = 1'b1;
    tick();
    check("wrap_ffffffff", cd_w, 32'hFFFF_FFFF);
    tick();
    check("wrap_zero", cd_w, 32'h0000_0000);
    tick();
    check("wrap_one", cd_w, 32'h0000_0001);

    // Long run against a +1 reference model
    check("rnd_rst", cd_r, RV_RND);
    rst_r = 1'b1;
    model = RV_RND;
    mism = 0;
    first_act = 32'd0;
    first_exp = 32'd0;
    for (int i = 0; i < RND_CYC; i++) begin
      tick();
      model = model + 32'd1;
      if (cd_r !== model) begin
        if (mism == 0) begin
          first_act = cd_r;
          first_exp = model;
        end
        mism++;
      end
    end
    if (mism != 0) $display("first divergence: actual=%h required=%h", first_act, first_exp);
    check("rnd_mismatches", mism, 32'd0);
    check("rnd_final", cd_r, RV_RND + RND_CYC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
